// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: WB write, ID read/issue and hazard signals of the register file
interface regfile_scoreboard_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              wb_write_reg_en_i;
  logic [ADDR_W-1:0] wb_write_reg_addr_i;
  logic [DATA_W-1:0] wb_write_reg_data_i;
  logic              id_read1_en_i;
  logic [ADDR_W-1:0] id_read1_addr_i;
  logic              id_read2_en_i;
  logic [ADDR_W-1:0] id_read2_addr_i;
  logic              id_issue_en_i;
  logic [ADDR_W-1:0] id_issue_addr_i;
  logic [DATA_W-1:0] id_read1_data_o;
  logic [DATA_W-1:0] id_read2_data_o;
  logic              id_stall_o;
  logic              sb_overflow_o;
  modport master (
    output wb_write_reg_en_i, wb_write_reg_addr_i, wb_write_reg_data_i,
    output id_read1_en_i, id_read1_addr_i, id_read2_en_i, id_read2_addr_i,
    output id_issue_en_i, id_issue_addr_i,
    input  id_read1_data_o, id_read2_data_o, id_stall_o, sb_overflow_o
  );
  modport slave (
    input  wb_write_reg_en_i, wb_write_reg_addr_i, wb_write_reg_data_i,
    input  id_read1_en_i, id_read1_addr_i, id_read2_en_i, id_read2_addr_i,
    input  id_issue_en_i, id_issue_addr_i,
    output id_read1_data_o, id_read2_data_o, id_stall_o, sb_overflow_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with WB bypass and per-register pending-write scoreboard
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave b
);
  localparam int NR = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [DATA_W-1:0] regs [NR];
  logic [CNT_W-1:0]  cnt  [NR];
  logic [NR-1:0]     inc, dec;
  logic              ovf, wb_hit1, wb_hit2, haz1, haz2;
  always_comb begin
    inc = b.id_issue_en_i ? NR'(1) << b.id_issue_addr_i : '0;
    dec = b.wb_write_reg_en_i ? NR'(1) << b.wb_write_reg_addr_i : '0;
    wb_hit1 = b.wb_write_reg_en_i && b.wb_write_reg_addr_i == b.id_read1_addr_i;
    wb_hit2 = b.wb_write_reg_en_i && b.wb_write_reg_addr_i == b.id_read2_addr_i;
    b.id_read1_data_o = (rst || !b.id_read1_en_i || b.id_read1_addr_i == '0) ? '0 :
                        wb_hit1 ? b.wb_write_reg_data_i : regs[b.id_read1_addr_i];
    b.id_read2_data_o = (rst || !b.id_read2_en_i || b.id_read2_addr_i == '0) ? '0 :
                        wb_hit2 ? b.wb_write_reg_data_i : regs[b.id_read2_addr_i];
    // a single pending writer that retires this cycle is covered by the bypass
    haz1 = b.id_read1_en_i && b.id_read1_addr_i != '0 &&
           (cnt[b.id_read1_addr_i] > CNT_W'(1) || (cnt[b.id_read1_addr_i] == CNT_W'(1) && !wb_hit1));
    haz2 = b.id_read2_en_i && b.id_read2_addr_i != '0 &&
           (cnt[b.id_read2_addr_i] > CNT_W'(1) || (cnt[b.id_read2_addr_i] == CNT_W'(1) && !wb_hit2));
    b.id_stall_o    = !rst && (haz1 || haz2);
    b.sb_overflow_o = !rst && ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      ovf <= 1'b0;
    end else begin
      if (b.wb_write_reg_en_i && b.wb_write_reg_addr_i != '0)
        regs[b.wb_write_reg_addr_i] <= b.wb_write_reg_data_i;
      for (int r = 1; r < NR; r++) begin
        if (inc[r] && !dec[r] && cnt[r] != CMAX) cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r] && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
      if (b.id_issue_en_i && b.id_issue_addr_i != '0 && !dec[b.id_issue_addr_i] &&
          cnt[b.id_issue_addr_i] == CMAX)
        ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed plan plus random traffic against an array-based model
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (.clk(clk), .rst(rst), .b(bus));
  int total = 0, bad = 0;
  logic [31:0] mreg [32];
  int mcnt [32];
  bit movf = 0;
  int xs = -1, xo = -1;
  logic xd_en = 0;
  logic [31:0] xd;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] erd(input logic r, we, input logic [4:0] wa, input logic [31:0] wd,
                                      input logic en, input logic [4:0] a);
    if (r || !en || a == 0) return 0;
    if (we && wa == a) return wd;
    return mreg[a];
  endfunction
  function automatic logic ehaz(input logic we, input logic [4:0] wa, input logic en, input logic [4:0] a);
    if (!en || a == 0) return 0;
    return mcnt[a] >= 2 || (mcnt[a] == 1 && !(we && wa == a));
  endfunction
  task automatic cyc(input logic r, we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                     input logic ie, input logic [4:0] ia);
    rst = r;
    bus.wb_write_reg_en_i = we; bus.wb_write_reg_addr_i = wa; bus.wb_write_reg_data_i = wd;
    bus.id_read1_en_i = e1; bus.id_read1_addr_i = a1;
    bus.id_read2_en_i = e2; bus.id_read2_addr_i = a2;
    bus.id_issue_en_i = ie; bus.id_issue_addr_i = ia;
    #3;
    chk("rd1", bus.id_read1_data_o, erd(r, we, wa, wd, e1, a1));
    chk("rd2", bus.id_read2_data_o, erd(r, we, wa, wd, e2, a2));
    chk("stall", 32'(bus.id_stall_o), 32'(!r && (ehaz(we, wa, e1, a1) || ehaz(we, wa, e2, a2))));
    chk("ovf", 32'(bus.sb_overflow_o), 32'(!r && movf));
    if (xs >= 0) chk("lit_stall", 32'(bus.id_stall_o), xs[31:0]);
    if (xo >= 0) chk("lit_ovf", 32'(bus.sb_overflow_o), xo[31:0]);
    if (xd_en) chk("lit_rd1", bus.id_read1_data_o, xd);
    xs = -1; xo = -1; xd_en = 0;
    @(posedge clk);
    if (r) begin
      foreach (mreg[i]) begin mreg[i] = 0; mcnt[i] = 0; end
      movf = 0;
    end else begin
      if (we && wa != 0) mreg[wa] = wd;
      if (!(ie && we && ia == wa)) begin
        if (ie && ia != 0) begin
          if (mcnt[ia] == 3) movf = 1;
          else mcnt[ia]++;
        end
        if (we && wa != 0 && mcnt[wa] > 0) mcnt[wa]--;
      end
    end
    #1;
  endtask
  task automatic rd(input logic [4:0] a);
    cyc(0, 0, 0, 0, 1, a, 0, 0, 0, 0);
  endtask
  task automatic iss(input logic [4:0] a);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
  endtask
  task automatic wbr(input logic [4:0] a, input logic [31:0] d);
    cyc(0, 1, a, d, 1, a, 0, 0, 0, 0);
  endtask
  initial begin
    foreach (mreg[i]) begin mreg[i] = 0; mcnt[i] = 0; end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom), 1, 5'($urandom), 1, 5'($urandom));
    xs = 0; xo = 0; xd = 0; xd_en = 1;
    cyc(1, 1, 4, 32'h1, 1, 4, 1, 9, 1, 4);
    xs = 0; xo = 0; xd = 0; xd_en = 1;
    cyc(1, 0, 0, 0, 1, 1, 1, 2, 0, 0);
    for (int i = 1; i < 32; i += 2) begin
      xd = 0; xd_en = 1; xs = 0;
      cyc(0, 0, 0, 0, 1, 5'(i), 1, 5'(i + 1), 0, 0);
    end
    xd = 32'hDEADBEEF; xd_en = 1;
    wbr(5, 32'hDEADBEEF);
    xd = 32'hDEADBEEF; xd_en = 1;
    rd(5);
    xd = 0; xd_en = 1; xs = 0;
    cyc(0, 1, 0, 32'h12345678, 1, 0, 1, 0, 1, 0);
    xd = 0; xd_en = 1; xs = 0;
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    iss(7);
    xs = 1; rd(7);
    xs = 0; xd = 32'hA5A5A5A5; xd_en = 1;
    wbr(7, 32'hA5A5A5A5);
    xs = 0; rd(7);
    iss(3); iss(3);
    xs = 1; wbr(3, 32'h33);
    xs = 0; cyc(0, 1, 3, 32'h34, 1, 3, 0, 0, 1, 3);
    xs = 1; rd(3);
    xs = 0; wbr(3, 32'h35);
    xs = 0; rd(3);
    for (int i = 0; i < 4; i++) iss(9);
    xs = 1; xo = 1; rd(9);
    xs = 1; wbr(9, 32'h91);
    xs = 1; wbr(9, 32'h92);
    xs = 0; xo = 1; wbr(9, 32'h93);
    xs = 0; xo = 1; rd(9);
    xo = 0; cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    xo = 0; rd(9);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 1), 5'($urandom_range(0, 6)), $urandom,
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 6)),
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 6)),
          $urandom_range(0, 1), 5'($urandom_range(0, 6)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural register file at the consuming end of the MEM/WB write-back interface.
- Accepts one write per cycle from the WB stage and serves two combinational read ports to the ID stage.
- Bypasses same-cycle write-back data to the read ports.
- Keeps a per-register pending-write scoreboard: ID marks destinations at issue, WB retires them, and the block raises a stall when a source operand is still in flight.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- CNT_W, 2, per-register pending-write counter width; max in-flight writers per register is 2**CNT_W-1 = 3.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_write_reg_en_i  input  1  write-back enable from the MEM/WB register.
- wb_write_reg_addr_i  input  ADDR_W  write-back destination.
- wb_write_reg_data_i  input  DATA_W  write-back data.
- id_read1_en_i  input  1  read port 1 enable.
- id_read1_addr_i  input  ADDR_W  read port 1 address.
- id_read2_en_i  input  1  read port 2 enable.
- id_read2_addr_i  input  ADDR_W  read port 2 address.
- id_issue_en_i  input  1  ID issues an instruction that will write a register.
- id_issue_addr_i  input  ADDR_W  destination of the issued instruction.
- id_read1_data_o  output  DATA_W  read port 1 data (combinational).
- id_read2_data_o  output  DATA_W  read port 2 data (combinational).
- id_stall_o  output  1  operand hazard: a source has an unretired writer.
- sb_overflow_o  output  1  sticky error: issue attempted on a register whose counter is saturated.

Behaviour:
- Reset:
  - While rst=1, both read data outputs = 0, id_stall_o = 0, sb_overflow_o = 0 (forced combinationally).
  - At the clock edge with rst=1, all registers clear to 0, all pending counters clear to 0, and sb_overflow_o clears.
  - Reset mid-operation discards all in-flight scoreboard state.
- Register 0:
  - Reads of address 0 always return 0.
  - Writes to address 0 are ignored.
  - Issue to address 0 does not touch any counter.
- Write:
  - When wb_write_reg_en_i=1 and the address is nonzero, regs[addr] <= data at the clock edge.
  - Write-to-read latency is 0 via the bypass below; the stored value is visible from the next cycle.
- Read port n, in priority order:
  - en=0 -> 0.
  - addr=0 -> 0.
  - wb_write_reg_en_i=1 and wb_write_reg_addr_i==addr -> wb_write_reg_data_i (bypass).
  - Otherwise regs[addr].
- Scoreboard, per register r != 0, with inc = issue_en && issue_addr==r and dec = wb_en && wb_addr==r:
  - inc only: cnt+1.
  - dec only: cnt-1, floored at 0; dec on cnt=0 is a no-op.
  - inc and dec together: cnt unchanged.
  - inc at cnt=2**CNT_W-1 (without dec): cnt holds and sb_overflow_o sets to 1 and stays set until reset.
- Stall:
  - A source is hazardous if its port is enabled, its address is nonzero, and either:
    - cnt>=2, or
    - cnt==1 and NOT (wb_en && wb_addr==addr).
  - id_stall_o is the OR over both ports.
  - A same-cycle issue does not affect stall; counters update at the edge only.
- id_stall_o is purely combinational from current counters and inputs. Squashing a stalled issue is the ID stage's job; this block honours id_issue_en_i as given.
- No other state. Outputs carry no registered latency.

Test Plan:
- Reset:
  - Drive rst=1 for 2 cycles after random writes -> reads of r1..r31 return 0, id_stall_o=0, sb_overflow_o=0.
- Write then read:
  - Write r5=0xDEADBEEF; read r5 the same cycle -> 0xDEADBEEF via bypass.
  - Next cycle with wb_en=0 -> 0xDEADBEEF from storage.
- Register 0:
  - Write r0=0x12345678 and issue to r0 -> read r0 returns 0; stall on a r0 source stays 0.
- Single hazard:
  - Issue r7, then read r7 on the next cycle -> stall=1.
  - On the cycle WB writes r7=0xA5A5A5A5 -> stall=0 and data=0xA5A5A5A5.
  - Afterwards cnt=0.
- WAW and simultaneous events:
  - Issue r3 twice (cnt=2); WB r3 while reading r3 -> stall=1 (cnt 2->1).
  - Issue r3 and WB r3 in the same cycle -> cnt unchanged.
  - Final WB r3 -> stall clears.
- Overflow:
  - Issue r9 four times with no WB -> after the 4th, sb_overflow_o=1 and cnt=3.
  - Three WBs to r9 -> cnt=0, stall=0, sb_overflow_o still 1 until rst.
